key_entry_parser: RTL and testbench
===================================

# key_entry_parser

Consumes the encoded key stream from the keypad scanner/encoder (8-bit key code plus debounced `pressed`) and turns it into calculator commands. It turns one physical press into one key event, builds two decimal operands, latches an operator, and presents a completed `{A, op, B}` command to the arithmetic unit with a valid/ready handshake. It sits between the keypad top level and the calculator datapath, and drives the live value to the display path.

## Interface
- `MAX_DIGITS`, 4, maximum decimal digits per operand
- `OPW`, 14, operand width; must hold 10^MAX_DIGITS − 1
- `clk` in 1: system clock
- `rst` in 1: synchronous, active-high reset
- `key_code` in 8: encoder output
  - 0x00–0x09: digits
  - 0xF1 ADD, 0xF2 SUB, 0xF3 MUL, 0xF4 DIV, 0xF5 EQU, 0xF6 CLEAR
  - 0xFF: none
- `key_pressed` in 1: debounced press level, high for the whole hold
- `cmd_ready` in 1: datapath accepts the command
- `cmd_valid` out 1: command available
- `operand_a` out OPW: first operand, binary
- `operand_b` out OPW: second operand, binary
- `op` out 3: 0 none, 1 ADD, 2 SUB, 3 MUL, 4 DIV
- `display_value` out OPW: number currently being entered
- `err` out 1: sticky error flag (digit overflow or divide by zero)

## Operation
- **Event detect:** `press_q` registers `key_pressed`. A key event is `key_pressed & ~press_q`, with `key_code` sampled in that cycle.
  - An event with code 0xFF or any undefined code is dropped.
  - Holding a key yields exactly one event.
- **States:** S_A (entering A), S_B (entering B), S_DONE (command pending).
- **S_A:**
  - Digit d with cnt < MAX_DIGITS: acc_a ← acc_a·10 + d, cnt++.
  - Digit with cnt = MAX_DIGITS: digit dropped, err ← 1.
  - Operator: op latched, cnt ← 0, go to S_B. With no digits entered, A = 0.
  - EQU: ignored.
- **S_B:**
  - Digits accumulate into acc_b under the same rules as S_A.
  - Operator with cnt = 0: replaces op. Operator with cnt > 0: ignored.
  - EQU with op = DIV and acc_b = 0: err ← 1, clear acc_a, acc_b, op and cnt, go to S_A, no command issued.
  - Any other EQU: go to S_DONE.
- **S_DONE:**
  - `cmd_valid` = 1; `operand_a`, `operand_b` and `op` are held stable.
  - On `cmd_valid & cmd_ready`: clear accumulators, op and cnt, go to S_A.
  - All key events are dropped, CLEAR included.
- **CLEAR (S_A or S_B):** accumulators, cnt, op and err ← 0; go to S_A.
- **err:** set only as above; cleared only by CLEAR or `rst`. Entry continues while err is set.
- **display_value:**
  - S_A: acc_a.
  - S_B: acc_b if cnt > 0, else acc_a.
  - S_DONE: acc_b.
- **Arithmetic:** ×10 is computed as (acc<<3)+(acc<<1) in OPW bits. The digit limit guarantees no wrap.

## Timing
- **Reset:** all outputs 0, state S_A, `press_q` 0. `rst` overrides every other input in the same cycle, including mid-command with `cmd_valid` high.
- **Event latency:** the event is seen in the first cycle `key_pressed` is high. Accumulator, state and `display_value` update at that clock edge and are visible the next cycle.
- **Command latency:** `cmd_valid` rises the cycle after the EQU event.
- **Handshake:**
  - `cmd_valid` never drops without acceptance.
  - Payload is stable while `cmd_valid` is high.
  - `cmd_ready` while `cmd_valid` is low is ignored.
  - Acceptance takes one cycle; `cmd_valid` is low and state is S_A the following cycle.
- **Event in the acceptance cycle:** dropped (state is still S_DONE).
- **Back-to-back presses:** events need a `key_pressed` low cycle between them. The upstream debouncer guarantees this.

## Structure
- **Shared package `keypad_pkg`:**
  - Key-code constants (digits, 0xF1–0xF6, 0xFF none)
  - Op encodings 0–4
  - State enum {S_A, S_B, S_DONE}
- **The encoder** uses the same key-code constants, so the encoder and this parser are defined by a single source.
- **Sub-module `key_digit_accum`:**
  - Inputs: `clk`, `rst`, `clr`, `digit_en`, `digit[3:0]`
  - Outputs: `value[OPW-1:0]`, `count`, `overflow` pulse
  - Instantiated twice, once for A and once for B.

## Test plan
- **Basic command:** keys 1,2,ADD,3,4,EQU, `cmd_ready` low for 10 cycles, then high → `cmd_valid` held 10+ cycles with A=12, B=34, op=1; dropped 1 cycle after acceptance; `display_value` = 0 afterwards.
- **Digit overflow:** keys 1,2,3,4,5 → A=1234, err=1; then CLEAR → everything 0, err=0.
- **Divide by zero:** keys 8,DIV,0,EQU → err=1, `cmd_valid` never asserts, state S_A, `display_value` = 0.
- **Held key:** `key_pressed` high for 1000 cycles with code 0x07 → acc_a = 7, exactly one event. Then 9999 entered → `display_value` = 9999.
- **Operator replacement:** keys 5,ADD,MUL,2,SUB,EQU → op=3, B=2, command issued.
- **Pending command and reset:** key events (including CLEAR) while in S_DONE → payload unchanged. `rst` pulse with `cmd_valid` high → all outputs 0 the next cycle.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared keypad definitions: key codes, operator encodings and parser states.
package keypad_pkg;

  localparam int unsigned KP_MAX_DIGITS = 4;
  localparam int unsigned KP_OPW        = 14;

  localparam logic [7:0] KEY_DIGIT_MAX = 8'h09;
  localparam logic [7:0] KEY_ADD       = 8'hF1;
  localparam logic [7:0] KEY_SUB       = 8'hF2;
  localparam logic [7:0] KEY_MUL       = 8'hF3;
  localparam logic [7:0] KEY_DIV       = 8'hF4;
  localparam logic [7:0] KEY_EQU       = 8'hF5;
  localparam logic [7:0] KEY_CLEAR     = 8'hF6;
  localparam logic [7:0] KEY_NONE      = 8'hFF;

  typedef enum logic [2:0] {
    OP_NONE = 3'd0,
    OP_ADD  = 3'd1,
    OP_SUB  = 3'd2,
    OP_MUL  = 3'd3,
    OP_DIV  = 3'd4
  } op_e;

  typedef enum logic [1:0] {
    S_A    = 2'd0,
    S_B    = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // Digit keys occupy 0x00..0x09.
  function automatic logic is_digit_key(input logic [7:0] code);
    return code <= KEY_DIGIT_MAX;
  endfunction

  // Arithmetic operator keys occupy 0xF1..0xF4; the low bits are the op encoding.
  function automatic logic is_op_key(input logic [7:0] code);
    return (code >= KEY_ADD) && (code <= KEY_DIV);
  endfunction

endpackage

// File: rtl/key_digit_accum.sv
// Decimal digit accumulator: value <- value*10 + digit, limited to MAX_DIGITS digits.
module key_digit_accum #(
  parameter int unsigned MAX_DIGITS = 4,
  parameter int unsigned OPW        = 14,
  parameter int unsigned CNTW       = $clog2(MAX_DIGITS + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr,
  input  logic            digit_en,
  input  logic [3:0]      digit,
  output logic [OPW-1:0]  value,
  output logic [CNTW-1:0] count,
  output logic            overflow
);

  logic [OPW-1:0]  value_q, value_d;
  logic [CNTW-1:0] count_q, count_d;
  logic            room;

  assign room = count_q < CNTW'(MAX_DIGITS);

  // Next value: clear wins, otherwise shift in a digit while there is room.
  always_comb begin
    value_d = value_q;
    count_d = count_q;
    if (clr) begin
      value_d = '0;
      count_d = '0;
    end else if (digit_en && room) begin
      value_d = (value_q << 3) + (value_q << 1) + OPW'(digit);
      count_d = count_q + CNTW'(1);
    end
  end

  // Accumulator and digit-count registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      value_q <= '0;
      count_q <= '0;
    end else begin
      value_q <= value_d;
      count_q <= count_d;
    end
  end

  assign value    = value_q;
  assign count    = count_q;
  assign overflow = digit_en & ~clr & ~room;

endmodule

// File: rtl/key_entry_parser.sv
// Turns keypad events into {A, op, B} calculator commands with a valid/ready handshake.
module key_entry_parser
  import keypad_pkg::*;
#(
  parameter int unsigned MAX_DIGITS = KP_MAX_DIGITS,
  parameter int unsigned OPW        = KP_OPW
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [7:0]     key_code,
  input  logic           key_pressed,
  input  logic           cmd_ready,
  output logic           cmd_valid,
  output logic [OPW-1:0] operand_a,
  output logic [OPW-1:0] operand_b,
  output logic [2:0]     op,
  output logic [OPW-1:0] display_value,
  output logic           err
);

  localparam int unsigned CNTW = $clog2(MAX_DIGITS + 1);

  state_e          state_q, state_d;
  op_e             op_q, op_d;
  logic            err_q, err_d;
  logic            press_q;

  logic            key_ev;
  logic            ev_digit, ev_op, ev_equ, ev_clear;
  logic            clr_acc, en_a, en_b;
  logic [OPW-1:0]  val_a, val_b;
  logic [CNTW-1:0] cnt_a, cnt_b;
  logic            ovf_a, ovf_b;

  assign key_ev   = key_pressed & ~press_q;
  assign ev_digit = key_ev & is_digit_key(key_code);
  assign ev_op    = key_ev & is_op_key(key_code);
  assign ev_equ   = key_ev & (key_code == KEY_EQU);
  assign ev_clear = key_ev & (key_code == KEY_CLEAR);

  key_digit_accum #(
    .MAX_DIGITS(MAX_DIGITS),
    .OPW       (OPW),
    .CNTW      (CNTW)
  ) u_accum_a (
    .clk     (clk),
    .rst     (rst),
    .clr     (clr_acc),
    .digit_en(en_a),
    .digit   (key_code[3:0]),
    .value   (val_a),
    .count   (cnt_a),
    .overflow(ovf_a)
  );

  key_digit_accum #(
    .MAX_DIGITS(MAX_DIGITS),
    .OPW       (OPW),
    .CNTW      (CNTW)
  ) u_accum_b (
    .clk     (clk),
    .rst     (rst),
    .clr     (clr_acc),
    .digit_en(en_b),
    .digit   (key_code[3:0]),
    .value   (val_b),
    .count   (cnt_b),
    .overflow(ovf_b)
  );

  // State, operator, error and press-edge registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_A;
      op_q    <= OP_NONE;
      err_q   <= 1'b0;
      press_q <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      err_q   <= err_d;
      press_q <= key_pressed;
    end
  end

  // Entry FSM: digit routing, operator latch, EQU/CLEAR handling and command acceptance.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    err_d   = err_q;
    clr_acc = 1'b0;
    en_a    = 1'b0;
    en_b    = 1'b0;
    unique case (state_q)
      S_A: begin
        if (ev_digit) begin
          en_a = 1'b1;
        end else if (ev_op) begin
          op_d    = op_e'(key_code[2:0]);
          state_d = S_B;
        end else if (ev_clear) begin
          clr_acc = 1'b1;
          op_d    = OP_NONE;
          err_d   = 1'b0;
        end
      end
      S_B: begin
        if (ev_digit) begin
          en_b = 1'b1;
        end else if (ev_op) begin
          if (cnt_b == '0) op_d = op_e'(key_code[2:0]);
        end else if (ev_equ) begin
          if ((op_q == OP_DIV) && (val_b == '0)) begin
            err_d   = 1'b1;
            clr_acc = 1'b1;
            op_d    = OP_NONE;
            state_d = S_A;
          end else begin
            state_d = S_DONE;
          end
        end else if (ev_clear) begin
          clr_acc = 1'b1;
          op_d    = OP_NONE;
          err_d   = 1'b0;
          state_d = S_A;
        end
      end
      S_DONE: begin
        // Key events are ignored while a command is pending.
        if (cmd_ready) begin
          clr_acc = 1'b1;
          op_d    = OP_NONE;
          state_d = S_A;
        end
      end
      default: begin
        state_d = S_A;
      end
    endcase
    if (ovf_a || ovf_b) err_d = 1'b1;
  end

  // Live value for the display: B once it has digits, otherwise A.
  always_comb begin
    display_value = val_a;
    unique case (state_q)
      S_A:     display_value = val_a;
      S_B:     display_value = (cnt_b != '0) ? val_b : val_a;
      S_DONE:  display_value = val_b;
      default: display_value = val_a;
    endcase
  end

  assign cmd_valid = (state_q == S_DONE);
  assign operand_a = val_a;
  assign operand_b = val_b;
  assign op        = op_q;
  assign err       = err_q;

endmodule

// File: tb/tb_key_entry_parser.sv
// Directed bench for key_entry_parser: key-press vector table plus hand-written corner sequences.
module tb_key_entry_parser;
  import keypad_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  key_code;
  logic        key_pressed;
  logic        cmd_ready;
  logic        cmd_valid;
  logic [13:0] operand_a;
  logic [13:0] operand_b;
  logic [2:0]  op;
  logic [13:0] display_value;
  logic        err;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [7:0]  code;
    logic        accept;
    logic [13:0] disp;
    logic [13:0] a;
    logic [13:0] b;
    logic [2:0]  op;
    logic        err;
    logic        valid;
  } vec_t;

  vec_t vecs[$];

  key_entry_parser dut (
    .clk          (clk),
    .rst          (rst),
    .key_code     (key_code),
    .key_pressed  (key_pressed),
    .cmd_ready    (cmd_ready),
    .cmd_valid    (cmd_valid),
    .operand_a    (operand_a),
    .operand_b    (operand_b),
    .op           (op),
    .display_value(display_value),
    .err          (err)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic [7:0] code, input logic accept,
                              input int disp, input int a, input int b,
                              input int o, input logic e, input logic v);
    vec_t t;
    t.code   = code;
    t.accept = accept;
    t.disp   = 14'(disp);
    t.a      = 14'(a);
    t.b      = 14'(b);
    t.op     = 3'(o);
    t.err    = e;
    t.valid  = v;
    return t;
  endfunction

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int disp, input int a, input int b,
                         input int o, input logic e, input logic v);
    chk({tag, ".disp"},  32'(display_value), 32'(disp));
    chk({tag, ".a"},     32'(operand_a),     32'(a));
    chk({tag, ".b"},     32'(operand_b),     32'(b));
    chk({tag, ".op"},    32'(op),            32'(o));
    chk({tag, ".err"},   32'(err),           32'(e));
    chk({tag, ".valid"}, 32'(cmd_valid),     32'(v));
  endtask

  // One-cycle press followed by a release; returns just after the event edge.
  task automatic press(input logic [7:0] c);
    @(negedge clk);
    key_code    = c;
    key_pressed = 1'b1;
    @(negedge clk);
    key_pressed = 1'b0;
    key_code    = KEY_NONE;
  endtask

  initial begin
    rst         = 1'b1;
    key_code    = KEY_NONE;
    key_pressed = 1'b0;
    cmd_ready   = 1'b0;

    // Basic command: 12 + 34
    vecs.push_back(mk(8'h01,     0,    1,    1,  0, 0, 0, 0));
    vecs.push_back(mk(8'h02,     0,   12,   12,  0, 0, 0, 0));
    vecs.push_back(mk(KEY_ADD,   0,   12,   12,  0, 1, 0, 0));
    vecs.push_back(mk(8'h03,     0,    3,   12,  3, 1, 0, 0));
    vecs.push_back(mk(8'h04,     0,   34,   12, 34, 1, 0, 0));
    vecs.push_back(mk(KEY_EQU,   1,   34,   12, 34, 1, 0, 1));
    // Digit overflow, ignored EQU and undefined codes, then CLEAR
    vecs.push_back(mk(8'h01,     0,    1,    1,  0, 0, 0, 0));
    vecs.push_back(mk(8'h02,     0,   12,   12,  0, 0, 0, 0));
    vecs.push_back(mk(8'h03,     0,  123,  123,  0, 0, 0, 0));
    vecs.push_back(mk(8'h04,     0, 1234, 1234,  0, 0, 0, 0));
    vecs.push_back(mk(8'h05,     0, 1234, 1234,  0, 0, 1, 0));
    vecs.push_back(mk(KEY_EQU,   0, 1234, 1234,  0, 0, 1, 0));
    vecs.push_back(mk(8'h0A,     0, 1234, 1234,  0, 0, 1, 0));
    vecs.push_back(mk(KEY_NONE,  0, 1234, 1234,  0, 0, 1, 0));
    vecs.push_back(mk(KEY_CLEAR, 0,    0,    0,  0, 0, 0, 0));
    // Divide by zero, entry continues with err set, then CLEAR
    vecs.push_back(mk(8'h08,     0,    8,    8,  0, 0, 0, 0));
    vecs.push_back(mk(KEY_DIV,   0,    8,    8,  0, 4, 0, 0));
    vecs.push_back(mk(8'h00,     0,    0,    8,  0, 4, 0, 0));
    vecs.push_back(mk(KEY_EQU,   0,    0,    0,  0, 0, 1, 0));
    vecs.push_back(mk(8'h06,     0,    6,    6,  0, 0, 1, 0));
    vecs.push_back(mk(KEY_CLEAR, 0,    0,    0,  0, 0, 0, 0));
    // Operator replacement: 5 ADD MUL 2 SUB EQU -> 5 * 2
    vecs.push_back(mk(8'h05,     0,    5,    5,  0, 0, 0, 0));
    vecs.push_back(mk(KEY_ADD,   0,    5,    5,  0, 1, 0, 0));
    vecs.push_back(mk(KEY_MUL,   0,    5,    5,  0, 3, 0, 0));
    vecs.push_back(mk(8'h02,     0,    2,    5,  2, 3, 0, 0));
    vecs.push_back(mk(KEY_SUB,   0,    2,    5,  2, 3, 0, 0));
    vecs.push_back(mk(KEY_EQU,   1,    2,    5,  2, 3, 0, 1));
    // Non-zero divide issues a command
    vecs.push_back(mk(8'h09,     0,    9,    9,  0, 0, 0, 0));
    vecs.push_back(mk(KEY_DIV,   0,    9,    9,  0, 4, 0, 0));
    vecs.push_back(mk(8'h03,     0,    3,    9,  3, 4, 0, 0));
    vecs.push_back(mk(KEY_EQU,   1,    3,    9,  3, 4, 0, 1));

    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk_all("reset", 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      press(vecs[i].code);
      chk_all($sformatf("v%0d", i), vecs[i].disp, vecs[i].a, vecs[i].b,
              vecs[i].op, vecs[i].err, vecs[i].valid);
      if (vecs[i].accept) begin
        for (int k = 0; k < 10; k++) begin
          @(negedge clk);
          chk($sformatf("v%0d.hold%0d.valid", i, k), 32'(cmd_valid), 1);
          chk($sformatf("v%0d.hold%0d.a", i, k),     32'(operand_a), 32'(vecs[i].a));
          chk($sformatf("v%0d.hold%0d.b", i, k),     32'(operand_b), 32'(vecs[i].b));
          chk($sformatf("v%0d.hold%0d.op", i, k),    32'(op),        32'(vecs[i].op));
        end
        cmd_ready = 1'b1;
        @(negedge clk);
        cmd_ready = 1'b0;
        chk_all($sformatf("v%0d.accepted", i), 0, 0, 0, 0, 0, 0);
      end
    end

    // Held key yields a single event
    @(negedge clk);
    key_code    = 8'h07;
    key_pressed = 1'b1;
    repeat (1000) @(negedge clk);
    chk_all("held", 7, 7, 0, 0, 0, 0);
    key_pressed = 1'b0;
    key_code    = KEY_NONE;
    press(KEY_CLEAR);
    for (int i = 0; i < 4; i++) press(8'h09);
    chk_all("max9999", 9999, 9999, 0, 0, 0, 0);
    press(KEY_CLEAR);

    // cmd_ready high while idle is ignored; with ready already high the command lasts one cycle
    cmd_ready = 1'b1;
    press(8'h01);
    press(KEY_ADD);
    press(8'h02);
    chk_all("rdy_idle", 2, 1, 2, 1, 0, 0);
    press(KEY_EQU);
    chk_all("rdy_cmd", 2, 1, 2, 1, 0, 1);
    @(negedge clk);
    chk_all("rdy_accept", 0, 0, 0, 0, 0, 0);
    cmd_ready = 1'b0;

    // Events while pending, then reset with cmd_valid high
    press(8'h04);
    press(KEY_SUB);
    press(8'h05);
    press(KEY_EQU);
    press(8'h06);
    press(KEY_CLEAR);
    press(KEY_MUL);
    chk_all("pending", 5, 4, 5, 2, 0, 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk_all("rst_pending", 0, 0, 0, 0, 0, 0);
    rst = 1'b0;

    // Key event in the acceptance cycle is dropped
    press(8'h03);
    press(KEY_ADD);
    press(8'h01);
    press(KEY_EQU);
    @(negedge clk);
    cmd_ready   = 1'b1;
    key_code    = 8'h07;
    key_pressed = 1'b1;
    @(negedge clk);
    cmd_ready   = 1'b0;
    key_pressed = 1'b0;
    key_code    = KEY_NONE;
    chk_all("accept_drop", 0, 0, 0, 0, 0, 0);
    press(8'h04);
    chk_all("after_accept", 4, 4, 0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
